mii_rx_checker: RTL and testbench
=================================

# mii_rx_checker

Receive-side checker that sits directly downstream of the 64-bit MII frame generator and consumes its data/control word stream (8 lanes, lane 0 = bits [7:0]). It delineates frames by START/TERMINATE control characters, validates preamble/SFD, control-character placement and frame length, and reports per-frame length and error status. It also maintains saturating good/bad frame counters for the verification environment.

## Interface
Parameters:
- PAYLOAD_MAX_SIZE, 1500: maximum payload bytes. Frames longer than PAYLOAD_MAX_SIZE+18 are oversize.
- MIN_FRAME_LEN, 64: minimum frame bytes, counted from destination address through FCS.

Ports (clock and reset first). Reset is i_rst_n, asynchronous, active-low; clock is clk.
- clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mii_rx_d  in  64  data word, lane k = bits [8k+7:8k].
- i_mii_rx_c  in  8  per-lane control flag; 1 = lane carries a control character.
- o_frame_done  out  1  one-cycle pulse when a frame ends.
- o_frame_len  out  16  frame byte count (destination address through FCS); saturates at 16'hFFFF.
- o_err  out  5  status of the reported frame, valid with o_frame_done. Bits: [0] bad preamble/SFD, [1] illegal control character, [2] runt, [3] oversize, [4] CRC error.
- o_good_cnt  out  32  count of frames with o_err==0; saturating.
- o_bad_cnt  out  32  count of frames with o_err!=0; saturating.
- o_in_frame  out  1  high while the FSM is in FRAME or DISCARD.

## Operation
- Control characters: IDLE 8'h07, START 8'hFB, TERMINATE 8'hFD. Any other value with its control bit set is illegal.
- Start word: c==8'h01, lane0==FB, lanes1–6==8'h55, lane7==8'hD5. START is recognised only in lane 0.
- FSM states: IDLE, FRAME, DISCARD.
- IDLE:
  - On a start word, clear the byte counter and the error accumulator, then go to FRAME.
  - If the word has c[0]=1 and lane0=FB but the preamble/SFD is bad, set err[0] and go to FRAME anyway, so the frame is still reported.
  - All-IDLE words are ignored.
  - Any other word is ignored silently; it is not counted.
- FRAME:
  - Let t = the lowest lane with c[t]=1 and d=FD.
  - If there is no t, all lanes must have c=0. Add 8 to the counter.
  - If t exists, add t bytes (lanes < t, which must have c=0). Lanes > t must be IDLE with c=1. The frame then ends: go to IDLE.
  - Any violation sets err[1].
  - A START (FB) seen inside the frame sets err[1] and goes to DISCARD.
- DISCARD:
  - Wait for any TERMINATE lane, then end the frame with the accumulated errors.
  - Bytes in DISCARD are not counted.
- Frame end:
  - err[2] = len < MIN_FRAME_LEN.
  - err[3] = len > PAYLOAD_MAX_SIZE+18.
  - Counters increment by 1 and hold at 32'hFFFFFFFF.
- Arithmetic: the byte counter is 16 bits, saturating. t is computed by a priority encoder from lane 0 upward.

## Timing
- Reset values: o_frame_done=0, o_frame_len=0, o_err=0, o_good_cnt=0, o_bad_cnt=0, o_in_frame=0. The FSM resets to IDLE.
- All outputs are registered.
- Latency: a TERMINATE word sampled at edge N produces o_frame_done=1 in the cycle after edge N, together with o_frame_len and o_err. Both hold until the next frame end.
- Counters update on the same edge as o_frame_done.
- o_in_frame rises on the edge that samples the start word. It falls on the edge that samples the TERMINATE word.
- A start word may follow a terminate word back-to-back (no IDLE word between). It is accepted on the very next edge.
- A terminate word in lane 0 immediately after the start word gives len=0, which sets err[2].
- Reset asserted mid-frame: the in-progress frame is dropped. No o_frame_done pulse, and counters clear.

## Configuration
- MII_CHK_CRC_EN defined:
  - Ethernet CRC-32 (reflected polynomial 0x04C11DB7, init 32'hFFFFFFFF) is computed over all counted bytes, up to 8 bytes per cycle.
  - At frame end, err[4] is set unless the CRC register equals the residue 32'hC704DD7B.
- MII_CHK_CRC_EN undefined: no CRC logic is built, and err[4] is tied to 0.

## Test plan
- 64-byte frame (payload 46), valid preamble: start word, 8 data words, then TERMINATE in lane 0 (c=8'hFF). Expect o_frame_done pulse one cycle later, o_frame_len=64, o_err=0, o_good_cnt=1.
- 68-byte frame (payload 50): the last word has TERMINATE in lane 4, c=8'hF0. Expect len=68, err=0. A second frame back-to-back gives o_good_cnt=2.
- Unpadded 10-byte payload (len=28): expect err=5'b00100, o_bad_cnt=1.
- Start word with lane7=8'hD4: expect err[0]=1. Length is still reported.
- Control 8'h9C mid-frame, then a START mid-frame: expect err[1]=1. Bytes after the START are not counted. Assert reset mid-frame: expect no pulse and all counters 0.
- With MII_CHK_CRC_EN: a frame with a correct FCS gives err=0. The same frame with one flipped FCS bit gives err=5'b10000.

Source files
------------

// File: rtl/mii_rx_checker.sv
// mii_rx_checker: delineates 64-bit MII frames and checks preamble/SFD, control placement, length (CRC-32 when MII_CHK_CRC_EN is defined).
// Latency: frame status and counters are registered one cycle after the TERMINATE word is sampled.
// Backpressure: none; one word is consumed every cycle.
module mii_rx_checker #(
    parameter int PAYLOAD_MAX_SIZE = 1500,
    parameter int MIN_FRAME_LEN    = 64
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_mii_rx_d,
    input  logic [7:0]  i_mii_rx_c,
    output logic        o_frame_done,
    output logic [15:0] o_frame_len,
    output logic [4:0]  o_err,
    output logic [31:0] o_good_cnt,
    output logic [31:0] o_bad_cnt,
    output logic        o_in_frame
);

    localparam logic [7:0]  C_IDLE    = 8'h07;
    localparam logic [7:0]  C_START   = 8'hFB;
    localparam logic [7:0]  C_TERM    = 8'hFD;
    localparam logic [63:0] START_WRD = 64'hD5555555555555FB;
    localparam logic [16:0] MIN_LEN   = 17'(MIN_FRAME_LEN);
    localparam logic [16:0] MAX_LEN   = 17'(PAYLOAD_MAX_SIZE + 18);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DISCARD} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [4:0]  r_err_acc, w_err_acc_nxt;
    logic        r_frame_done;
    logic [15:0] r_frame_len;
    logic [4:0]  r_err;
    logic [31:0] r_good_cnt, r_bad_cnt;

    logic [7:0]  w_is_term, w_is_start, w_is_idle;
    logic [7:0]  w_below_t, w_above_t;
    logic [2:0]  w_t;
    logic        w_has_t;
    logic        w_start_lane0, w_start_ok, w_term_viol;
    logic [3:0]  w_add;
    logic [16:0] w_sum;
    logic [15:0] w_cnt_sat;
    logic        w_end;
    logic [4:0]  w_end_err;
    logic        w_crc_bad;

    always_comb begin
        w_is_term  = 8'h00;
        w_is_start = 8'h00;
        w_is_idle  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            w_is_term[k]  = i_mii_rx_c[k] && (i_mii_rx_d[8*k +: 8] == C_TERM);
            w_is_start[k] = i_mii_rx_c[k] && (i_mii_rx_d[8*k +: 8] == C_START);
            w_is_idle[k]  = i_mii_rx_c[k] && (i_mii_rx_d[8*k +: 8] == C_IDLE);
        end
    end

    // Priority encoder: scanning downward leaves the lowest TERMINATE lane.
    always_comb begin
        w_has_t = 1'b0;
        w_t     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_is_term[k]) begin
                w_has_t = 1'b1;
                w_t     = 3'(k);
            end
        end
        w_below_t = 8'h00;
        w_above_t = 8'h00;
        for (int k = 0; k < 8; k++) begin
            w_below_t[k] = w_has_t && (k < int'(w_t));
            w_above_t[k] = w_has_t && (k > int'(w_t));
        end
    end

    assign w_start_lane0 = i_mii_rx_c[0] && (i_mii_rx_d[7:0] == C_START);
    assign w_start_ok    = (i_mii_rx_c == 8'h01) && (i_mii_rx_d == START_WRD);
    assign w_term_viol   = (|(i_mii_rx_c & w_below_t)) || (|(w_above_t & ~w_is_idle));
    assign w_add         = w_has_t ? {1'b0, w_t} : 4'd8;
    assign w_sum         = {1'b0, r_cnt} + {13'd0, w_add};
    assign w_cnt_sat     = w_sum[16] ? 16'hFFFF : w_sum[15:0];

`ifdef MII_CHK_CRC_EN
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    logic [31:0] r_crc, w_crc_nxt, w_crc_rev;
    logic [7:0]  w_crc_en;
    logic        w_crc_clr;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    assign w_crc_clr = (r_state == S_IDLE) && w_start_lane0;

    always_comb begin
        w_crc_en = 8'h00;
        if (r_state == S_FRAME) begin
            if (w_has_t)
                w_crc_en = w_below_t;
            else if (~|w_is_start)
                w_crc_en = 8'hFF;
        end
        w_crc_nxt = r_crc;
        for (int k = 0; k < 8; k++)
            if (w_crc_en[k])
                w_crc_nxt = crc_byte(w_crc_nxt, i_mii_rx_d[8*k +: 8]);
    end

    // The shift register holds the reflected form; the residue is quoted in normal bit order.
    assign w_crc_rev = {<<{w_crc_nxt}};
    assign w_crc_bad = (w_crc_rev != CRC_RESIDUE);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_crc <= 32'hFFFFFFFF;
        else if (w_crc_clr)
            r_crc <= 32'hFFFFFFFF;
        else
            r_crc <= w_crc_nxt;
    end
`else
    assign w_crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_err_acc_nxt = r_err_acc;
        w_end         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_lane0) begin
                    w_state_nxt   = S_FRAME;
                    w_cnt_nxt     = 16'd0;
                    w_err_acc_nxt = {4'd0, ~w_start_ok};
                end
            end
            S_FRAME: begin
                if (w_has_t) begin
                    w_cnt_nxt = w_cnt_sat;
                    if (w_term_viol)
                        w_err_acc_nxt[1] = 1'b1;
                    w_end       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (|w_is_start) begin
                    w_err_acc_nxt[1] = 1'b1;
                    w_state_nxt      = S_DISCARD;
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                    if (|i_mii_rx_c)
                        w_err_acc_nxt[1] = 1'b1;
                end
            end
            S_DISCARD: begin
                if (|w_is_term) begin
                    w_end       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_end_err    = w_err_acc_nxt;
        w_end_err[2] = ({1'b0, w_cnt_nxt} < MIN_LEN);
        w_end_err[3] = ({1'b0, w_cnt_nxt} > MAX_LEN);
        w_end_err[4] = w_crc_bad;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= 16'd0;
            r_err_acc    <= 5'd0;
            r_frame_done <= 1'b0;
            r_frame_len  <= 16'd0;
            r_err        <= 5'd0;
            r_good_cnt   <= 32'd0;
            r_bad_cnt    <= 32'd0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_err_acc    <= w_err_acc_nxt;
            r_frame_done <= w_end;
            if (w_end) begin
                r_frame_len <= w_cnt_nxt;
                r_err       <= w_end_err;
                if (|w_end_err) begin
                    if (r_bad_cnt != 32'hFFFFFFFF)
                        r_bad_cnt <= r_bad_cnt + 32'd1;
                end else begin
                    if (r_good_cnt != 32'hFFFFFFFF)
                        r_good_cnt <= r_good_cnt + 32'd1;
                end
            end
        end
    end

    assign o_frame_done = r_frame_done;
    assign o_frame_len  = r_frame_len;
    assign o_err        = r_err;
    assign o_good_cnt   = r_good_cnt;
    assign o_bad_cnt    = r_bad_cnt;
    assign o_in_frame   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mii_rx_checker.sv
// Directed bench for mii_rx_checker: frames built with a correct trailing FCS, boundary lengths, error cases, mid-frame reset.
module tb_mii_rx_checker;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [63:0] rx_d;
    logic [7:0]  rx_c;
    logic        frame_done;
    logic [15:0] frame_len;
    logic [4:0]  err;
    logic [31:0] good_cnt, bad_cnt;
    logic        in_frame;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] fb [0:2047];

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
`ifdef MII_CHK_CRC_EN
    localparam logic [4:0] CRCB = 5'b10000;
`else
    localparam logic [4:0] CRCB = 5'b00000;
`endif

    mii_rx_checker dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_mii_rx_d   (rx_d),
        .i_mii_rx_c   (rx_c),
        .o_frame_done (frame_done),
        .o_frame_len  (frame_len),
        .o_err        (err),
        .o_good_cnt   (good_cnt),
        .o_bad_cnt    (bad_cnt),
        .o_in_frame   (in_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [63:0] d, input logic [7:0] c);
        rx_d = d;
        rx_c = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    // n frame bytes (n>=4) whose last four are the Ethernet FCS, then TERMINATE in lane n%8.
    task automatic send_frame(input int n, input logic [7:0] sfd, input bit flip);
        logic [31:0] crc;
        logic [63:0] d;
        logic [7:0]  c;
        int nw, r;
        put({sfd, 48'h555555555555, 8'hFB}, 8'h01);
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            fb[i] = 8'(i * 13 + 5);
            crc = crc_upd(crc, fb[i]);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) fb[n - 4 + i] = crc[8*i +: 8];
        if (flip) fb[n - 1][0] = ~fb[n - 1][0];
        nw = n / 8;
        r  = n % 8;
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = fb[8*w + k];
            put(d, 8'h00);
        end
        for (int k = 0; k < 8; k++)
            d[8*k +: 8] = (k < r) ? fb[8*nw + k] : ((k == r) ? 8'hFD : 8'h07);
        c = 8'hFF << r;
        put(d, c);
    endtask

    task automatic check_end(input string tag, input logic [15:0] len, input logic [4:0] e,
                             input logic [31:0] g, input logic [31:0] b);
        check({tag, "_done"}, 64'(frame_done), 64'd1);
        check({tag, "_len"},  64'(frame_len), 64'(len));
        check({tag, "_err"},  64'(err), 64'(e));
        check({tag, "_good"}, 64'(good_cnt), 64'(g));
        check({tag, "_bad"},  64'(bad_cnt), 64'(b));
        check({tag, "_inf"},  64'(in_frame), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        rx_d = IDLE_W;
        rx_c = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_len",  64'(frame_len), 64'd0);
        check("rst_err",  64'(err), 64'd0);
        check("rst_good", 64'(good_cnt), 64'd0);
        check("rst_bad",  64'(bad_cnt), 64'd0);
        check("rst_inf",  64'(in_frame), 64'd0);
        i_rst_n = 1'b1;
        put(IDLE_W, 8'hFF);
        put(IDLE_W, 8'hFF);
        check("idle_inf", 64'(in_frame), 64'd0);

        send_frame(64, 8'hD5, 1'b0);
        check_end("f64", 16'd64, 5'b00000, 32'd1, 32'd0);
        put(IDLE_W, 8'hFF);
        check("pulse_low", 64'(frame_done), 64'd0);
        check("len_hold",  64'(frame_len), 64'd64);

        send_frame(68, 8'hD5, 1'b0);
        check_end("f68", 16'd68, 5'b00000, 32'd2, 32'd0);
        send_frame(64, 8'hD5, 1'b0);
        check_end("b2b", 16'd64, 5'b00000, 32'd3, 32'd0);

        send_frame(28, 8'hD5, 1'b0);
        check_end("runt28", 16'd28, 5'b00100, 32'd3, 32'd1);
        send_frame(63, 8'hD5, 1'b0);
        check_end("runt63", 16'd63, 5'b00100, 32'd3, 32'd2);
        send_frame(1518, 8'hD5, 1'b0);
        check_end("max1518", 16'd1518, 5'b00000, 32'd4, 32'd2);
        send_frame(1519, 8'hD5, 1'b0);
        check_end("over1519", 16'd1519, 5'b01000, 32'd4, 32'd3);

        put(IDLE_W, 8'hFF);
        send_frame(64, 8'hD4, 1'b0);
        check_end("badsfd", 16'd64, 5'b00001, 32'd4, 32'd4);

        put(64'hD5555555555555FB, 8'h01);
        put(64'h07070707070707FD, 8'hFF);
        check_end("len0", 16'd0, 5'b00100 | CRCB, 32'd4, 32'd5);

        put(64'hD5555555555555FB, 8'h01);
        check("disc_inf0", 64'(in_frame), 64'd1);
        put(64'h0011223344556677, 8'h00);
        put(64'h8899AABBCCDDEEFF, 8'h00);
        check("disc_nodone", 64'(frame_done), 64'd0);
        put(64'h010203049C050607, 8'h08);
        put(64'h1111111111111111, 8'h00);
        put(64'h2222222222222222, 8'h00);
        put(64'h11223344556677FB, 8'h01);
        check("disc_inf1", 64'(in_frame), 64'd1);
        put(64'h3333333333333333, 8'h00);
        put(64'h4444444444444444, 8'h00);
        put(64'h5555555555555555, 8'h00);
        put(64'h0707070707FD1234, 8'hFC);
        check_end("discard", 16'd40, 5'b00110 | CRCB, 32'd4, 32'd6);

`ifdef MII_CHK_CRC_EN
        send_frame(64, 8'hD5, 1'b1);
        check_end("crcflip", 16'd64, 5'b10000, 32'd4, 32'd7);
`endif

        put(IDLE_W, 8'hFF);
        put(64'hD5555555555555FB, 8'h01);
        put(64'h0101010101010101, 8'h00);
        put(64'h0202020202020202, 8'h00);
        i_rst_n = 1'b0;
        #1;
        check("mrst_done", 64'(frame_done), 64'd0);
        check("mrst_inf",  64'(in_frame), 64'd0);
        check("mrst_good", 64'(good_cnt), 64'd0);
        check("mrst_bad",  64'(bad_cnt), 64'd0);
        check("mrst_len",  64'(frame_len), 64'd0);
        put(64'h0303030303030303, 8'h00);
        put(64'h07070707070707FD, 8'hFF);
        check("mrst_nopulse", 64'(frame_done), 64'd0);
        i_rst_n = 1'b1;
        put(IDLE_W, 8'hFF);
        check("mrst_nopulse2", 64'(frame_done), 64'd0);
        send_frame(64, 8'hD5, 1'b0);
        check_end("recover", 16'd64, 5'b00000, 32'd1, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
